// File: rtl/vga_timing_pkg.sv
// Shared definitions for the raster timing generator.
//   timing_t        : one complete raster description (active/porch/sync widths, polarities)
//   VGA_640X480_60  : 640x480 @ 60 Hz preset, 25.175 MHz pixel clock
//   VGA_800X600_72  : 800x600 @ 72 Hz preset, 50 MHz pixel clock
//   axis_total()    : total pixels (lines) of one axis
//   calc_cw()       : smallest counter width that can hold 0..total-1
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    bit          h_pol;
    bit          v_pol;
  } timing_t;

  localparam timing_t VGA_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    h_pol: 1'b0, v_pol: 1'b0
  };

  localparam timing_t VGA_800X600_72 = '{
    h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
    v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
    h_pol: 1'b1, v_pol: 1'b1
  };

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Width needed so that 2^w >= total, i.e. every value 0..total-1 fits.
  function automatic int calc_cw(input int total);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(total)) w++;
    return w;
  endfunction

endpackage

// File: rtl/vga_timing_gen_timing_axis_counter.sv
// One raster axis: a free-running position counter with window decode.
//   clk, reset  : clock, synchronous active-high reset
//   ce          : advance enable (pixel enable for H, pixel enable & line wrap for V)
//   cnt         : current position, 0..TOTAL-1
//   wrap        : cnt is the last position of the axis
//   in_active   : cnt lies in the visible region
//   in_sync     : sync window expressed at the pin level, POL inside the window,
//                 ~POL outside, so the top can register it straight onto the pin
module timing_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          in_active,
  output logic          in_sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0 || CW == 0) begin : g_bad_width
    $error("timing_axis_counter: all widths must be non-zero");
  end

  if (CW < calc_cw(TOTAL)) begin : g_bad_cw
    $error("timing_axis_counter: CW too small for axis total");
  end

  // All window edges are strictly below TOTAL, so they fit in CW bits.
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (ce) begin
      if (wrap) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

  assign wrap      = (cnt == LAST);
  assign in_active = (cnt < ACTIVE_END);
  assign in_sync   = ((cnt >= SYNC_START) && (cnt < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator.
//   clk        : system / pixel clock
//   reset      : synchronous active-high reset, wins over pix_ce
//   pix_ce     : pixel clock-enable, tie high when clk is the pixel clock
//   hsync      : horizontal sync at H_POL level
//   vsync      : vertical sync at V_POL level
//   de         : visible pixel
//   hblank     : horizontal blanking (x >= H_ACTIVE)
//   vblank     : vertical blanking (y >= V_ACTIVE)
//   x, y       : position of the pixel the other outputs describe
//   sof        : one-clk pulse with the first pixel of a frame
//   eol        : one-clk pulse with the last pixel of a line
//   frame_cnt  : completed frames, wraps at 2^FCW
// Every output is a flop loaded from the same counter snapshot, so all of
// them describe the same pixel in the same cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_640X480_60.h_active,
  parameter int H_FP     = VGA_640X480_60.h_fp,
  parameter int H_SYNC   = VGA_640X480_60.h_sync,
  parameter int H_BP     = VGA_640X480_60.h_bp,
  parameter int V_ACTIVE = VGA_640X480_60.v_active,
  parameter int V_FP     = VGA_640X480_60.v_fp,
  parameter int V_SYNC   = VGA_640X480_60.v_sync,
  parameter int V_BP     = VGA_640X480_60.v_bp,
  parameter bit H_POL    = VGA_640X480_60.h_pol,
  parameter bit V_POL    = VGA_640X480_60.v_pol,
  parameter int CW       = 10,
  parameter int FCW      = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_ce,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           hblank,
  output logic           vblank,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           sof,
  output logic           eol,
  output logic [FCW-1:0] frame_cnt
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  if (FCW == 0 || CW == 0) begin : g_bad_width
    $error("vga_timing_gen: CW and FCW must be non-zero");
  end

  if (CW < calc_cw(MAX_TOTAL)) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0]  hc;
  logic [CW-1:0]  vc;
  logic           h_wrap;
  logic           v_wrap;
  logic           h_active;
  logic           v_active;
  logic           h_sync_lvl;
  logic           v_sync_lvl;
  logic           v_ce;
  logic [FCW-1:0] frame_q;

  assign v_ce = pix_ce & h_wrap;

  timing_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk       (clk),
    .reset     (reset),
    .ce        (pix_ce),
    .cnt       (hc),
    .wrap      (h_wrap),
    .in_active (h_active),
    .in_sync   (h_sync_lvl)
  );

  timing_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk       (clk),
    .reset     (reset),
    .ce        (v_ce),
    .cnt       (vc),
    .wrap      (v_wrap),
    .in_active (v_active),
    .in_sync   (v_sync_lvl)
  );

  // Internal count bumps as the counters roll over to (0,0); the output copy
  // is loaded with the rest of the snapshot, so it changes together with sof.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
    end else if (v_ce && v_wrap) begin
      frame_q <= frame_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      de        <= 1'b0;
      hblank    <= 1'b0;
      vblank    <= 1'b0;
      hsync     <= ~H_POL;
      vsync     <= ~V_POL;
      sof       <= 1'b0;
      eol       <= 1'b0;
      frame_cnt <= '0;
    end else if (pix_ce) begin
      x         <= hc;
      y         <= vc;
      de        <= h_active & v_active;
      hblank    <= ~h_active;
      vblank    <= ~v_active;
      hsync     <= h_sync_lvl;
      vsync     <= v_sync_lvl;
      sof       <= (hc == '0) && (vc == '0);
      eol       <= h_wrap;
      frame_cnt <= frame_q;
    end else begin
      // Pulses last one clk no matter how sparse pix_ce is.
      sof <= 1'b0;
      eol <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Three instances share clk/reset/pix_ce:
//   d0 : default 640x480 timing
//   d1 : small active-high sync timing, 4-bit frame counter
//   d2 : tiny 7x6 raster, 8-bit frame counter (frame wrap)
// The reference model tracks a linear pixel index per frame and derives x/y
// with division, then applies the output rules directly.
module tb_vga_timing_gen;

  logic clk;
  logic reset;
  logic pix_ce;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       hs0, vs0, de0, hb0, vb0, sof0, eol0;
  logic [9:0] x0, y0;
  logic [7:0] fc0;
  logic       hs1, vs1, de1, hb1, vb1, sof1, eol1;
  logic [5:0] x1, y1;
  logic [3:0] fc1;
  logic       hs2, vs2, de2, hb2, vb2, sof2, eol2;
  logic [2:0] x2, y2;
  logic [7:0] fc2;

  vga_timing_gen u_dut0 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(hs0), .vsync(vs0), .de(de0), .hblank(hb0), .vblank(vb0),
    .x(x0), .y(y0), .sof(sof0), .eol(eol0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(12), .V_FP(3), .V_SYNC(2), .V_BP(4),
    .H_POL(1'b1), .V_POL(1'b1), .CW(6), .FCW(4)
  ) u_dut1 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(hs1), .vsync(vs1), .de(de1), .hblank(hb1), .vblank(vb1),
    .x(x1), .y(y1), .sof(sof1), .eol(eol1), .frame_cnt(fc1)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(3), .FCW(8)
  ) u_dut2 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(hs2), .vsync(vs2), .de(de2), .hblank(hb2), .vblank(vb2),
    .x(x2), .y(y2), .sof(sof2), .eol(eol2), .frame_cnt(fc2)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] fc;
    logic hs, vs, de, hb, vb, sof, eol;
  } obs_t;

  int c_ha[3]  = '{640, 20, 4};
  int c_hf[3]  = '{16, 4, 1};
  int c_hs[3]  = '{96, 6, 1};
  int c_hb[3]  = '{48, 5, 1};
  int c_va[3]  = '{480, 12, 3};
  int c_vf[3]  = '{10, 3, 1};
  int c_vs[3]  = '{2, 2, 1};
  int c_vb[3]  = '{33, 4, 1};
  int c_hp[3]  = '{0, 1, 0};
  int c_vp[3]  = '{0, 1, 0};
  int c_fcw[3] = '{8, 4, 8};

  int   pos[3]    = '{0, 0, 0};
  int   frames[3] = '{0, 0, 0};
  obs_t held[3];

  obs_t q0[$];
  obs_t q1[$];
  obs_t q2[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit abort   = 0;
  bit saw_wrap = 0;

  task automatic model_step(input int k, input bit rst, input bit ce, output obs_t e);
    int ht, vt, hc, vc, h_s0, v_s0;
    ht = c_ha[k] + c_hf[k] + c_hs[k] + c_hb[k];
    vt = c_va[k] + c_vf[k] + c_vs[k] + c_vb[k];
    if (rst) begin
      pos[k] = 0;
      frames[k] = 0;
      e.x = 0; e.y = 0; e.fc = 0;
      e.de = 0; e.hb = 0; e.vb = 0; e.sof = 0; e.eol = 0;
      e.hs = (c_hp[k] == 0);
      e.vs = (c_vp[k] == 0);
    end else if (ce) begin
      hc = pos[k] % ht;
      vc = pos[k] / ht;
      h_s0 = c_ha[k] + c_hf[k];
      v_s0 = c_va[k] + c_vf[k];
      e.x   = 32'(hc);
      e.y   = 32'(vc);
      e.de  = (hc < c_ha[k]) && (vc < c_va[k]);
      e.hb  = (hc >= c_ha[k]);
      e.vb  = (vc >= c_va[k]);
      e.hs  = ((hc >= h_s0) && (hc < h_s0 + c_hs[k])) ? (c_hp[k] != 0) : (c_hp[k] == 0);
      e.vs  = ((vc >= v_s0) && (vc < v_s0 + c_vs[k])) ? (c_vp[k] != 0) : (c_vp[k] == 0);
      e.sof = (pos[k] == 0);
      e.eol = (hc == ht - 1);
      e.fc  = 32'(frames[k] % (1 << c_fcw[k]));
      pos[k] = (pos[k] + 1) % (ht * vt);
      if (pos[k] == 0) frames[k]++;
    end else begin
      e = held[k];
      e.sof = 0;
      e.eol = 0;
    end
    held[k] = e;
  endtask

  task automatic drive(input bit rst, input bit ce);
    obs_t e;
    if (abort) return;
    @(negedge clk);
    reset  = rst;
    pix_ce = ce;
    model_step(0, rst, ce, e); q0.push_back(e);
    model_step(1, rst, ce, e); q1.push_back(e);
    model_step(2, rst, ce, e); q2.push_back(e);
  endtask

  task automatic cmp(input int k, input string n, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL d%0d %s actual=%0d expected=%0d t=%0t", k, n, a, e, $time);
      if (n_fail >= 50) abort = 1;
    end
  endtask

  task automatic check(input int k, input obs_t a, input obs_t e);
    cmp(k, "x", a.x, e.x);
    cmp(k, "y", a.y, e.y);
    cmp(k, "frame_cnt", a.fc, e.fc);
    cmp(k, "hsync", 32'(a.hs), 32'(e.hs));
    cmp(k, "vsync", 32'(a.vs), 32'(e.vs));
    cmp(k, "de", 32'(a.de), 32'(e.de));
    cmp(k, "hblank", 32'(a.hb), 32'(e.hb));
    cmp(k, "vblank", 32'(a.vb), 32'(e.vb));
    cmp(k, "sof", 32'(a.sof), 32'(e.sof));
    cmp(k, "eol", 32'(a.eol), 32'(e.eol));
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    obs_t a, e;
    logic [7:0] prev_fc2;
    logic [2:0] prev_sof;
    logic [2:0] prev_eol;
    prev_fc2 = '0;
    prev_sof = '0;
    prev_eol = '0;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a.x = 32'(x0); a.y = 32'(y0); a.fc = 32'(fc0);
        a.hs = hs0; a.vs = vs0; a.de = de0; a.hb = hb0; a.vb = vb0; a.sof = sof0; a.eol = eol0;
        check(0, a, e);
        cmp(0, "sof_width", 32'(prev_sof[0] & sof0), 32'd0);
        cmp(0, "eol_width", 32'(prev_eol[0] & eol0), 32'd0);
        prev_sof[0] = sof0; prev_eol[0] = eol0;
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a.x = 32'(x1); a.y = 32'(y1); a.fc = 32'(fc1);
        a.hs = hs1; a.vs = vs1; a.de = de1; a.hb = hb1; a.vb = vb1; a.sof = sof1; a.eol = eol1;
        check(1, a, e);
        prev_sof[1] = sof1; prev_eol[1] = eol1;
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        a.x = 32'(x2); a.y = 32'(y2); a.fc = 32'(fc2);
        a.hs = hs2; a.vs = vs2; a.de = de2; a.hb = hb2; a.vb = vb2; a.sof = sof2; a.eol = eol2;
        check(2, a, e);
        cmp(2, "sof_width", 32'(prev_sof[2] & sof2), 32'd0);
        cmp(2, "eol_width", 32'(prev_eol[2] & eol2), 32'd0);
        if (sof2 === 1'b1 && fc2 === 8'd0 && prev_fc2 === 8'd255) saw_wrap = 1;
        prev_fc2 = fc2;
        prev_sof[2] = sof2; prev_eol[2] = eol2;
      end
    end
  end

  initial begin
    int n;
    reset  = 1'b1;
    pix_ce = 1'b0;

    repeat (3) drive(1, bit'($urandom_range(0, 1)));

    // Run d0 to x=300, y=1, show that pixel, then reset mid-line.
    n = 0;
    while (pos[0] != 800 + 300 && n < 3000 && !abort) begin
      drive(0, 1);
      n++;
    end
    n_tests++;
    if (pos[0] != 800 + 300) begin
      n_fail++;
      $display("FAIL reach_x300 actual_pos=%0d expected_pos=%0d", pos[0], 1100);
    end
    drive(0, 1);
    drive(1, 1);
    repeat (2000) drive(0, 1);

    // Half-rate pixel enable.
    repeat (1000) begin
      drive(0, 1);
      drive(0, 0);
    end

    // Random enable pattern with occasional resets.
    repeat (30000) drive($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0);

    // Continuous enable: d2 runs well past 256 frames.
    repeat (12000) drive(0, 1);

    repeat (3) @(negedge clk);

    n_tests++;
    if (!saw_wrap && !abort) begin
      n_fail++;
      $display("FAIL frame_wrap_with_sof actual=%0d expected=%0d", saw_wrap, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
